camera_bringup_ctrl: RTL
========================

CAMERA_BRINGUP_CTRL -- requirements
Module: camera_bringup_ctrl

Interface
REQ-001 SHALL have parameter PWDN_CYCLES, default 25000, cycles cam_pwdn held high at power-cycle start.
REQ-002 SHALL have parameter RST_CYCLES, default 25000, cycles cam_reset_n held low after pwdn release.
REQ-003 SHALL have parameter BOOT_CYCLES, default 25000, cycles waited after reset release before configuration.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2500000, maximum cycles waited for cfg_done.
REQ-005 SHALL have parameter SETTLE_FRAMES, default 10, vsync frames discarded after configuration; legal range 1..255.
REQ-006 SHALL have parameter MAX_RETRIES, default 3, configuration retries before FAIL; legal range 0..3.
REQ-007 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 SHALL have port enable  input  1  level request for camera bring-up; low aborts.
REQ-010 SHALL have port cfg_done  input  1  done from the SCCB register-configuration engine.
REQ-011 SHALL have port vsync  input  1  camera vsync, asynchronous to clk.
REQ-012 SHALL have port cam_pwdn  output  1  camera power-down pin, high = powered down.
REQ-013 SHALL have port cam_reset_n  output  1  camera hardware reset pin, active-low.
REQ-014 SHALL have port cfg_start  output  1  single-cycle start pulse to the configuration engine.
REQ-015 SHALL have port capture_en  output  1  enables the pixel capture path.
REQ-016 SHALL have port ready  output  1  camera configured and streaming.
REQ-017 SHALL have port error  output  1  bring-up failed after all retries.
REQ-018 SHALL have port retry_count  output  2  number of timeouts in the current bring-up.

Function
REQ-019 SHALL implement states IDLE, PWDN, HWRST, BOOT, CFG_START, CFG_WAIT, SETTLE, ALIGN, RUN, FAIL; all outputs registered.
REQ-020 SHALL pass vsync through a 2-flop synchroniser; edge detection uses the synchronised signal and one further delay register.
REQ-021 IDLE: cam_pwdn=1, cam_reset_n=0, all other outputs 0; enable=1 -> PWDN next cycle.
REQ-022 PWDN: cam_pwdn=1, cam_reset_n=0 for exactly PWDN_CYCLES cycles -> HWRST.
REQ-023 HWRST: cam_pwdn=0, cam_reset_n=0 for exactly RST_CYCLES cycles -> BOOT.
REQ-024 BOOT: cam_pwdn=0, cam_reset_n=1 for exactly BOOT_CYCLES cycles -> CFG_START.
REQ-025 CFG_START: lasts one cycle, cfg_start=1 only in this state -> CFG_WAIT.
REQ-026 CFG_WAIT: rising edge of cfg_done (high now, low previous cycle) -> SETTLE; a cfg_done held high from an earlier run SHALL NOT count.
REQ-027 CFG_WAIT: TIMEOUT_CYCLES cycles without a cfg_done rising edge -> timeout; if retry_count < MAX_RETRIES, increment retry_count and -> PWDN (full power cycle), else -> FAIL.
REQ-028 cfg_done edge and timeout in the same cycle: edge wins -> SETTLE.
REQ-029 SETTLE: count synchronised vsync rising edges; on the SETTLE_FRAMES-th -> ALIGN.
REQ-030 ALIGN: on the next synchronised vsync falling edge -> RUN; capture_en and ready go to 1 on entry to RUN.
REQ-031 RUN: capture_en=1, ready=1, cam_pwdn=0, cam_reset_n=1, held while enable=1.
REQ-032 FAIL: error=1, cam_pwdn=1, cam_reset_n=0, retry_count holds final value; held while enable=1.
REQ-033 enable=0 in any state -> IDLE next cycle, counters and retry_count cleared; takes priority over all other transitions.
REQ-034 One down-counter, 24 bits minimum, shared by the PWDN, HWRST, BOOT and CFG_WAIT states and reloaded on each state entry; a separate 8-bit frame counter serves SETTLE.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE, cam_pwdn=1, cam_reset_n=0, cfg_start=0, capture_en=0, ready=0, error=0, retry_count=0, counters 0, synchroniser flops 0.
REQ-036 Release of rst_n with enable=1 SHALL start bring-up (IDLE -> PWDN) on the first clock edge after release.

Verification (PWDN=4, RST=4, BOOT=8, TIMEOUT=20, SETTLE_FRAMES=2, MAX_RETRIES=2)
REQ-037 enable=1; cfg_done pulses 5 cycles after cfg_start; 2 vsync frames -> cam_pwdn low after 4 cycles, cam_reset_n high 4 cycles later, cfg_start pulse 8 cycles later, ready=capture_en=1 on the first vsync fall after the 2nd rise, retry_count=0.
REQ-038 cfg_done never asserted -> exactly 3 cfg_start pulses, each preceded by a full pwdn/reset cycle, retry_count 1 then 2, error=1 20 cycles after the 3rd pulse, ready=0.
REQ-039 Timeout once, cfg_done on 2nd attempt -> RUN with retry_count=1, error=0.
REQ-040 cfg_done held high before and through CFG_WAIT -> no advance, timeout at 20 cycles.
REQ-041 enable dropped in SETTLE, and separately in RUN -> next cycle IDLE outputs: cam_pwdn=1, capture_en=0, ready=0, retry_count=0; re-raise -> full sequence restarts.
REQ-042 rst_n pulsed low mid-CFG_WAIT -> outputs at reset values asynchronously; bring-up restarts from PWDN after release.

Source files
------------

// File: rtl/camera_bringup_ctrl.sv
// camera_bringup_ctrl
// Power-up and configuration sequencer for an image sensor. It runs these
// steps in order:
//   1. Holds the camera powered down.
//   2. Holds the camera in hardware reset.
//   3. Waits for the sensor to boot.
//   4. Kicks the SCCB configuration engine and waits for it to finish.
//      A timeout retries with a full power cycle.
//   5. Discards a number of settling frames.
//   6. Aligns to a vsync falling edge and then enables capture.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   enable       level request for bring-up; low returns to IDLE
//   cfg_done     done from the configuration engine (clk domain)
//   vsync        camera vsync, asynchronous to clk
//   cam_pwdn     camera power-down pin (1 = powered down)
//   cam_reset_n  camera hardware reset pin (active-low)
//   cfg_start    one-cycle start pulse to the configuration engine
//   capture_en   enables the pixel capture path
//   ready        camera configured and streaming
//   error        bring-up failed after all retries
//   retry_count  configuration timeouts seen in the current bring-up
module camera_bringup_ctrl #(
  parameter int PWDN_CYCLES    = 25000,
  parameter int RST_CYCLES     = 25000,
  parameter int BOOT_CYCLES    = 25000,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int SETTLE_FRAMES  = 10,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       cfg_done,
  input  logic       vsync,
  output logic       cam_pwdn,
  output logic       cam_reset_n,
  output logic       cfg_start,
  output logic       capture_en,
  output logic       ready,
  output logic       error,
  output logic [1:0] retry_count
);

  // Shared delay counter is at least 24 bits, widened if any delay needs more.
  localparam int MAX_A  = (PWDN_CYCLES > RST_CYCLES) ? PWDN_CYCLES : RST_CYCLES;
  localparam int MAX_B  = (BOOT_CYCLES > TIMEOUT_CYCLES) ? BOOT_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int NEED_W = $clog2(MAX_AB + 1);
  localparam int CNT_W  = (NEED_W > 24) ? NEED_W : 24;

  // Counters are loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] PWDN_LOAD    = CNT_W'(PWDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOOT_LOAD    = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [7:0]       SETTLE_LAST  = 8'(SETTLE_FRAMES - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  typedef enum logic [3:0] {
    IDLE,
    PWDN,
    HWRST,
    BOOT,
    CFG_START,
    CFG_WAIT,
    SETTLE,
    ALIGN,
    RUN,
    FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       frame_q, frame_d;
  logic [1:0]       retry_q, retry_d;
  logic             vs_meta_q, vs_meta_d;
  logic             vs_sync_q, vs_sync_d;
  logic             vs_dly_q, vs_dly_d;
  logic             cfg_done_dly_q, cfg_done_dly_d;
  logic             cam_pwdn_q, cam_pwdn_d;
  logic             cam_reset_n_q, cam_reset_n_d;
  logic             cfg_start_q, cfg_start_d;
  logic             capture_en_q, capture_en_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;

  logic vs_rise;
  logic vs_fall;
  logic cfg_rise;

  assign vs_rise  = vs_sync_q & ~vs_dly_q;
  assign vs_fall  = ~vs_sync_q & vs_dly_q;
  // A cfg_done that was already high before entering CFG_WAIT shows no edge.
  assign cfg_rise = cfg_done & ~cfg_done_dly_q;

  // Next-state, counter and registered-output logic. Outputs are decoded
  // from the next state so they change on the same edge as the state.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    frame_d        = frame_q;
    retry_d        = retry_q;
    vs_meta_d      = vsync;
    vs_sync_d      = vs_meta_q;
    vs_dly_d       = vs_sync_q;
    cfg_done_dly_d = cfg_done;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      frame_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = PWDN;
          cnt_d   = PWDN_LOAD;
        end
        PWDN: begin
          if (cnt_q == '0) begin
            state_d = HWRST;
            cnt_d   = RST_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        HWRST: begin
          if (cnt_q == '0) begin
            state_d = BOOT;
            cnt_d   = BOOT_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        BOOT: begin
          if (cnt_q == '0) begin
            state_d = CFG_START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        CFG_START: begin
          state_d = CFG_WAIT;
          cnt_d   = TIMEOUT_LOAD;
        end
        CFG_WAIT: begin
          // A done edge beats a timeout that expires in the same cycle.
          if (cfg_rise) begin
            state_d = SETTLE;
            cnt_d   = '0;
            frame_d = '0;
          end else if (cnt_q == '0) begin
            if (retry_q < RETRY_LIMIT) begin
              retry_d = retry_q + 2'd1;
              state_d = PWDN;
              cnt_d   = PWDN_LOAD;
            end else begin
              state_d = FAIL;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        SETTLE: begin
          if (vs_rise) begin
            if (frame_q == SETTLE_LAST) begin
              state_d = ALIGN;
              frame_d = '0;
            end else begin
              frame_d = frame_q + 8'd1;
            end
          end
        end
        ALIGN: begin
          if (vs_fall) begin
            state_d = RUN;
          end
        end
        RUN:     state_d = RUN;
        FAIL:    state_d = FAIL;
        default: state_d = IDLE;
      endcase
    end

    cam_pwdn_d    = (state_d == IDLE) || (state_d == PWDN) || (state_d == FAIL);
    cam_reset_n_d = (state_d == BOOT) || (state_d == CFG_START) || (state_d == CFG_WAIT) ||
                    (state_d == SETTLE) || (state_d == ALIGN) || (state_d == RUN);
    cfg_start_d   = (state_d == CFG_START);
    capture_en_d  = (state_d == RUN);
    ready_d       = (state_d == RUN);
    error_d       = (state_d == FAIL);
  end

  // State, counters, synchroniser and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      frame_q        <= '0;
      retry_q        <= '0;
      vs_meta_q      <= 1'b0;
      vs_sync_q      <= 1'b0;
      vs_dly_q       <= 1'b0;
      cfg_done_dly_q <= 1'b0;
      cam_pwdn_q     <= 1'b1;
      cam_reset_n_q  <= 1'b0;
      cfg_start_q    <= 1'b0;
      capture_en_q   <= 1'b0;
      ready_q        <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      frame_q        <= frame_d;
      retry_q        <= retry_d;
      vs_meta_q      <= vs_meta_d;
      vs_sync_q      <= vs_sync_d;
      vs_dly_q       <= vs_dly_d;
      cfg_done_dly_q <= cfg_done_dly_d;
      cam_pwdn_q     <= cam_pwdn_d;
      cam_reset_n_q  <= cam_reset_n_d;
      cfg_start_q    <= cfg_start_d;
      capture_en_q   <= capture_en_d;
      ready_q        <= ready_d;
      error_q        <= error_d;
    end
  end

  assign cam_pwdn    = cam_pwdn_q;
  assign cam_reset_n = cam_reset_n_q;
  assign cfg_start   = cfg_start_q;
  assign capture_en  = capture_en_q;
  assign ready       = ready_q;
  assign error       = error_q;
  assign retry_count = retry_q;

endmodule
